// File: rtl/dm_bus_ctrl_if.sv
// Request/response bus of the data-memory controller together with the
// SRAM, I/O and internal-register side ports it drives and samples.
interface dm_bus_ctrl_if #(
  parameter int ADDR_W = 16,
  parameter int N_IREG = 3
);
  logic                  req;
  logic                  req_we;
  logic [ADDR_W-1:0]     req_addr;
  logic [7:0]            req_wdata;
  logic                  busy;
  logic [7:0]            rd_data;
  logic                  rd_valid;
  logic                  err;
  logic [ADDR_W-1:0]     dm_addr;
  logic                  dm_re;
  logic                  dm_we;
  logic [7:0]            dm_wdata;
  logic                  dm_ready;
  logic [7:0]            dm_rdata;
  logic [7:0]            io_addr;
  logic                  io_re;
  logic                  io_we;
  logic [7:0]            io_wdata;
  logic [7:0]            io_rdata;
  logic [N_IREG-1:0]     ireg_we;
  logic [7:0]            ireg_wdata;
  logic [8*N_IREG-1:0]   ireg_rdata;

  modport slave (
    input  req, req_we, req_addr, req_wdata, dm_ready, dm_rdata, io_rdata, ireg_rdata,
    output busy, rd_data, rd_valid, err, dm_addr, dm_re, dm_we, dm_wdata,
           io_addr, io_re, io_we, io_wdata, ireg_we, ireg_wdata
  );

  modport master (
    output req, req_we, req_addr, req_wdata, dm_ready, dm_rdata, io_rdata, ireg_rdata,
    input  busy, rd_data, rd_valid, err, dm_addr, dm_re, dm_we, dm_wdata,
           io_addr, io_re, io_we, io_wdata, ireg_we, ireg_wdata
  );
endinterface

// File: rtl/dm_bus_ctrl.sv
// Data-memory bus controller: decodes each accepted request into an
// internal-register, I/O, SRAM or null access and sequences the strobes.
// Optional feature macro: DM_TIMEOUT_EN (SRAM access timeout with err strobe).
module dm_bus_ctrl #(
  parameter int ADDR_W      = 16,
  parameter int IO_BASE     = 16'h0020,
  parameter int IO_SIZE     = 224,
  parameter int N_IREG      = 3,
  parameter int IREG_BASE   = 8'h3D,
  parameter int WAIT_STATES = 0,
  parameter int TIMEOUT     = 15
) (
  input  logic          clock,
  input  logic          reset,
  dm_bus_ctrl_if.slave  bus
);

  localparam int IDX_W = (N_IREG > 1) ? $clog2(N_IREG) : 1;
  localparam int WC_W  = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
  localparam logic [ADDR_W-1:0] IO_LO = ADDR_W'(IO_BASE);
  localparam logic [ADDR_W:0]   IO_HI = (ADDR_W + 1)'(IO_BASE + IO_SIZE);
  localparam logic [7:0]        IR_B8 = 8'(IREG_BASE);
  localparam logic [8:0]        IR_LO = 9'(IREG_BASE);
  localparam logic [8:0]        IR_HI = 9'(IREG_BASE + N_IREG);

  typedef enum logic [2:0] {S_IDLE, S_SRAM, S_IO, S_IREG, S_NULL} state_t;

  state_t              state_q, state_d;
  logic                we_q, we_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [WC_W-1:0]     wcnt_q, wcnt_d;
  logic [7:0]          rd_data_q, rd_data_d;
  logic                rd_valid_q, rd_valid_d;
  logic [ADDR_W-1:0]   dm_addr_q, dm_addr_d;
  logic                dm_re_q, dm_re_d;
  logic                dm_we_q, dm_we_d;
  logic [7:0]          dm_wdata_q, dm_wdata_d;
  logic [7:0]          io_addr_q, io_addr_d;
  logic                io_re_q, io_re_d;
  logic                io_we_q, io_we_d;
  logic [7:0]          io_wdata_q, io_wdata_d;
  logic [N_IREG-1:0]   ireg_we_q, ireg_we_d;
  logic [7:0]          ireg_wdata_q, ireg_wdata_d;

`ifdef DM_TIMEOUT_EN
  localparam int TC_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  logic [TC_W-1:0]     tcnt_q, tcnt_d;
  logic                err_q, err_d;
`endif

  logic                below_w, above_w, is_ireg_w;
  logic [7:0]          io_off_w;
  logic [IDX_W-1:0]    ireg_idx_w;
  logic [7:0]          ireg_sel_w;

  // Address decode of the incoming request, evaluated in the accepting cycle.
  assign io_off_w   = 8'(bus.req_addr - IO_LO);
  assign below_w    = (bus.req_addr < IO_LO);
  assign above_w    = ({1'b0, bus.req_addr} >= IO_HI);
  assign is_ireg_w  = !below_w && !above_w &&
                      ({1'b0, io_off_w} >= IR_LO) && ({1'b0, io_off_w} < IR_HI);
  assign ireg_idx_w = IDX_W'(io_off_w - IR_B8);

  // Pick the internal register slice addressed by the latched index.
  always_comb begin
    ireg_sel_w = 8'h00;
    for (int k = 0; k < N_IREG; k++) begin
      if (idx_q == IDX_W'(k)) ireg_sel_w = bus.ireg_rdata[8*k +: 8];
    end
  end

  // Next-state and registered-output logic of the access sequencer.
  always_comb begin
    state_d      = state_q;
    we_d         = we_q;
    idx_d        = idx_q;
    wcnt_d       = wcnt_q;
    rd_data_d    = rd_data_q;
    rd_valid_d   = 1'b0;
    dm_addr_d    = dm_addr_q;
    dm_re_d      = dm_re_q;
    dm_we_d      = dm_we_q;
    dm_wdata_d   = dm_wdata_q;
    io_addr_d    = io_addr_q;
    io_re_d      = 1'b0;
    io_we_d      = 1'b0;
    io_wdata_d   = io_wdata_q;
    ireg_we_d    = '0;
    ireg_wdata_d = ireg_wdata_q;
`ifdef DM_TIMEOUT_EN
    tcnt_d       = tcnt_q;
    err_d        = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.req) begin
          we_d = bus.req_we;
          if (is_ireg_w) begin
            state_d      = S_IREG;
            idx_d        = ireg_idx_w;
            ireg_wdata_d = bus.req_wdata;
            if (bus.req_we) ireg_we_d = N_IREG'(1) << ireg_idx_w;
          end else if (!below_w && !above_w) begin
            state_d    = S_IO;
            io_addr_d  = io_off_w;
            io_wdata_d = bus.req_wdata;
            io_re_d    = !bus.req_we;
            io_we_d    = bus.req_we;
          end else if (above_w) begin
            state_d    = S_SRAM;
            dm_addr_d  = bus.req_addr;
            dm_wdata_d = bus.req_wdata;
            dm_re_d    = !bus.req_we;
            dm_we_d    = bus.req_we;
            wcnt_d     = WC_W'(WAIT_STATES);
`ifdef DM_TIMEOUT_EN
            tcnt_d     = '0;
`endif
          end else begin
            state_d = S_NULL;
          end
        end
      end
      S_IO: begin
        state_d = S_IDLE;
        if (!we_q) begin
          rd_data_d  = bus.io_rdata;
          rd_valid_d = 1'b1;
        end
      end
      S_IREG: begin
        state_d = S_IDLE;
        if (!we_q) begin
          rd_data_d  = ireg_sel_w;
          rd_valid_d = 1'b1;
        end
      end
      S_NULL: begin
        state_d = S_IDLE;
        if (!we_q) begin
          rd_data_d  = 8'h00;
          rd_valid_d = 1'b1;
        end
      end
      S_SRAM: begin
        if (wcnt_q != '0) begin
          wcnt_d = wcnt_q - 1'b1;
        end else if (bus.dm_ready) begin
          state_d = S_IDLE;
          dm_re_d = 1'b0;
          dm_we_d = 1'b0;
          if (!we_q) begin
            rd_data_d  = bus.dm_rdata;
            rd_valid_d = 1'b1;
          end
`ifdef DM_TIMEOUT_EN
        end else if (tcnt_q == TC_W'(TIMEOUT - 1)) begin
          state_d = S_IDLE;
          dm_re_d = 1'b0;
          dm_we_d = 1'b0;
          err_d   = 1'b1;
          if (!we_q) begin
            rd_data_d  = 8'hFF;
            rd_valid_d = 1'b1;
          end
        end else begin
          tcnt_d = tcnt_q + 1'b1;
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers; reset clears control and data alike.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= S_IDLE;
      we_q         <= 1'b0;
      idx_q        <= '0;
      wcnt_q       <= '0;
      rd_data_q    <= 8'h00;
      rd_valid_q   <= 1'b0;
      dm_addr_q    <= '0;
      dm_re_q      <= 1'b0;
      dm_we_q      <= 1'b0;
      dm_wdata_q   <= 8'h00;
      io_addr_q    <= 8'h00;
      io_re_q      <= 1'b0;
      io_we_q      <= 1'b0;
      io_wdata_q   <= 8'h00;
      ireg_we_q    <= '0;
      ireg_wdata_q <= 8'h00;
`ifdef DM_TIMEOUT_EN
      tcnt_q       <= '0;
      err_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      we_q         <= we_d;
      idx_q        <= idx_d;
      wcnt_q       <= wcnt_d;
      rd_data_q    <= rd_data_d;
      rd_valid_q   <= rd_valid_d;
      dm_addr_q    <= dm_addr_d;
      dm_re_q      <= dm_re_d;
      dm_we_q      <= dm_we_d;
      dm_wdata_q   <= dm_wdata_d;
      io_addr_q    <= io_addr_d;
      io_re_q      <= io_re_d;
      io_we_q      <= io_we_d;
      io_wdata_q   <= io_wdata_d;
      ireg_we_q    <= ireg_we_d;
      ireg_wdata_q <= ireg_wdata_d;
`ifdef DM_TIMEOUT_EN
      tcnt_q       <= tcnt_d;
      err_q        <= err_d;
`endif
    end
  end

  assign bus.busy       = (state_q != S_IDLE);
  assign bus.rd_data    = rd_data_q;
  assign bus.rd_valid   = rd_valid_q;
  assign bus.dm_addr    = dm_addr_q;
  assign bus.dm_re      = dm_re_q;
  assign bus.dm_we      = dm_we_q;
  assign bus.dm_wdata   = dm_wdata_q;
  assign bus.io_addr    = io_addr_q;
  assign bus.io_re      = io_re_q;
  assign bus.io_we      = io_we_q;
  assign bus.io_wdata   = io_wdata_q;
  assign bus.ireg_we    = ireg_we_q;
  assign bus.ireg_wdata = ireg_wdata_q;

`ifdef DM_TIMEOUT_EN
  assign bus.err = err_q;
`else
  // Without the timeout feature SRAM waits forever and err never fires.
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT != 0);
  assign bus.err        = 1'b0;
`endif

endmodule

// File: tb/tb_dm_bus_ctrl.sv
// Bench for dm_bus_ctrl: one instance with default parameters (b0) and one
// with WAIT_STATES=2 (b2); expected read data flows through per-instance queues.
module tb_dm_bus_ctrl;
  logic clock = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;
  logic [7:0] q0[$];
  logic [7:0] q2[$];

  dm_bus_ctrl_if #(.ADDR_W(16), .N_IREG(3)) b0();
  dm_bus_ctrl_if #(.ADDR_W(16), .N_IREG(3)) b2();

  dm_bus_ctrl #(.WAIT_STATES(0)) u0 (.clock(clock), .reset(reset), .bus(b0));
  dm_bus_ctrl #(.WAIT_STATES(2)) u2 (.clock(clock), .reset(reset), .bus(b2));

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Present one request at a falling edge; returns at the next falling edge.
  task automatic drive0(input logic we, input logic [15:0] addr, input logic [7:0] wd);
    b0.req = 1'b1; b0.req_we = we; b0.req_addr = addr; b0.req_wdata = wd;
    @(posedge clock);
    @(negedge clock);
    b0.req = 1'b0;
  endtask

  task automatic drive2(input logic we, input logic [15:0] addr, input logic [7:0] wd);
    b2.req = 1'b1; b2.req_we = we; b2.req_addr = addr; b2.req_wdata = wd;
    @(posedge clock);
    @(negedge clock);
    b2.req = 1'b0;
  endtask

  // Counts edges from acceptance until rd_valid is seen (bounded at 40).
  task automatic wait_valid0(output int lat);
    lat = 1;
    while (b0.rd_valid !== 1'b1 && lat < 40) begin
      @(negedge clock);
      lat++;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    b0.req = 1'b1; b0.req_we = 1'b0; b0.req_addr = 16'h0100; b0.req_wdata = 8'h00;
    b0.dm_ready = 1'b0; b0.dm_rdata = 8'h00; b0.io_rdata = 8'h00; b0.ireg_rdata = '0;
    b2.req = 1'b0; b2.req_we = 1'b0; b2.req_addr = 16'h0000; b2.req_wdata = 8'h00;
    b2.dm_ready = 1'b0; b2.dm_rdata = 8'h00; b2.io_rdata = 8'h00; b2.ireg_rdata = '0;
    repeat (2) @(negedge clock);
    total++; if (b0.busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%0h want=0", b0.busy); end
    total++; if (b0.dm_re !== 1'b0) begin bad++; $display("FAIL rst_dm_re got=%0h want=0", b0.dm_re); end
    total++; if (b0.rd_valid !== 1'b0) begin bad++; $display("FAIL rst_rd_valid got=%0h want=0", b0.rd_valid); end
    total++; if (b0.rd_data !== 8'h00) begin bad++; $display("FAIL rst_rd_data got=%0h want=0", b0.rd_data); end
    total++; if (b0.dm_addr !== 16'h0000) begin bad++; $display("FAIL rst_dm_addr got=%0h want=0", b0.dm_addr); end
    total++; if (b0.io_addr !== 8'h00) begin bad++; $display("FAIL rst_io_addr got=%0h want=0", b0.io_addr); end
    total++; if (b0.ireg_we !== 3'b000) begin bad++; $display("FAIL rst_ireg_we got=%0h want=0", b0.ireg_we); end
    total++; if (b0.err !== 1'b0) begin bad++; $display("FAIL rst_err got=%0h want=0", b0.err); end
    total++; if (b2.busy !== 1'b0) begin bad++; $display("FAIL rst_busy2 got=%0h want=0", b2.busy); end
    reset = 1'b0;
    b0.req = 1'b0;
    @(negedge clock);
    total++; if (b0.busy !== 1'b0) begin bad++; $display("FAIL rst_idle_after got=%0h want=0", b0.busy); end
  endtask

  task automatic test_sram_read;
    int lat;
    b0.dm_ready = 1'b1; b0.dm_rdata = 8'hA5;
    q0.push_back(8'hA5);
    drive0(1'b0, 16'h0100, 8'h00);
    total++; if (b0.dm_re !== 1'b1) begin bad++; $display("FAIL sram_rd_re got=%0h want=1", b0.dm_re); end
    total++; if (b0.dm_addr !== 16'h0100) begin bad++; $display("FAIL sram_rd_addr got=%0h want=0100", b0.dm_addr); end
    total++; if (b0.busy !== 1'b1) begin bad++; $display("FAIL sram_rd_busy got=%0h want=1", b0.busy); end
    wait_valid0(lat);
    total++; if (lat !== 2) begin bad++; $display("FAIL sram_rd_latency got=%0d want=2", lat); end
    total++; if (b0.dm_re !== 1'b0) begin bad++; $display("FAIL sram_rd_re_drop got=%0h want=0", b0.dm_re); end
    total++;
    if (q0.size() == 0) begin bad++; $display("FAIL sram_rd_data got=empty-queue want=a5"); end
    else begin
      logic [7:0] e; e = q0.pop_front();
      if (b0.rd_data !== e) begin bad++; $display("FAIL sram_rd_data got=%0h want=%0h", b0.rd_data, e); end
    end
    @(negedge clock);
    total++; if (b0.rd_valid !== 1'b0) begin bad++; $display("FAIL sram_rd_valid_pulse got=%0h want=0", b0.rd_valid); end
  endtask

  task automatic test_sram_write_ws2;
    int we_n = 0, busy_n = 0, v_n = 0;
    b2.dm_ready = 1'b0;
    drive2(1'b1, 16'h0200, 8'h3C);
    total++; if (b2.dm_wdata !== 8'h3C) begin bad++; $display("FAIL ws2_wdata got=%0h want=3c", b2.dm_wdata); end
    total++; if (b2.dm_addr !== 16'h0200) begin bad++; $display("FAIL ws2_addr got=%0h want=0200", b2.dm_addr); end
    for (int i = 0; i < 8; i++) begin
      if (b2.dm_we === 1'b1) we_n++;
      if (b2.busy === 1'b1) busy_n++;
      if (b2.rd_valid === 1'b1) v_n++;
      if (i == 1) b2.dm_ready = 1'b1;
      @(negedge clock);
    end
    b2.dm_ready = 1'b0;
    total++; if (we_n !== 3) begin bad++; $display("FAIL ws2_we_cycles got=%0d want=3", we_n); end
    total++; if (busy_n !== 3) begin bad++; $display("FAIL ws2_busy_cycles got=%0d want=3", busy_n); end
    total++; if (v_n !== 0) begin bad++; $display("FAIL ws2_no_valid got=%0d want=0", v_n); end
  endtask

  task automatic test_ireg;
    int lat;
    b0.ireg_rdata = 24'h80_22_11;
    drive0(1'b1, 16'h005E, 8'h55);
    total++; if (b0.ireg_we !== 3'b010) begin bad++; $display("FAIL ireg_we got=%0b want=010", b0.ireg_we); end
    total++; if (b0.ireg_wdata !== 8'h55) begin bad++; $display("FAIL ireg_wdata got=%0h want=55", b0.ireg_wdata); end
    total++; if (b0.io_we !== 1'b0) begin bad++; $display("FAIL ireg_io_we got=%0h want=0", b0.io_we); end
    @(negedge clock);
    total++; if (b0.ireg_we !== 3'b000) begin bad++; $display("FAIL ireg_we_pulse got=%0b want=000", b0.ireg_we); end
    total++; if (b0.rd_valid !== 1'b0) begin bad++; $display("FAIL ireg_wr_valid got=%0h want=0", b0.rd_valid); end
    q0.push_back(8'h80);
    drive0(1'b0, 16'h005F, 8'h00);
    wait_valid0(lat);
    total++; if (lat !== 2) begin bad++; $display("FAIL ireg_rd_latency got=%0d want=2", lat); end
    total++;
    if (q0.size() == 0) begin bad++; $display("FAIL ireg_rd_data got=empty-queue want=80"); end
    else begin
      logic [7:0] e; e = q0.pop_front();
      if (b0.rd_data !== e) begin bad++; $display("FAIL ireg_rd_data got=%0h want=%0h", b0.rd_data, e); end
    end
  endtask

  task automatic test_io_null;
    int lat;
    b0.io_rdata = 8'h5A;
    q0.push_back(8'h5A);
    drive0(1'b0, 16'h0025, 8'h00);
    total++; if (b0.io_re !== 1'b1) begin bad++; $display("FAIL io_re got=%0h want=1", b0.io_re); end
    total++; if (b0.io_addr !== 8'h05) begin bad++; $display("FAIL io_addr got=%0h want=05", b0.io_addr); end
    wait_valid0(lat);
    total++; if (lat !== 2) begin bad++; $display("FAIL io_rd_latency got=%0d want=2", lat); end
    total++;
    if (q0.size() == 0) begin bad++; $display("FAIL io_rd_data got=empty-queue want=5a"); end
    else begin
      logic [7:0] e; e = q0.pop_front();
      if (b0.rd_data !== e) begin bad++; $display("FAIL io_rd_data got=%0h want=%0h", b0.rd_data, e); end
    end
    drive0(1'b1, 16'h0040, 8'hC3);
    total++; if (b0.io_we !== 1'b1) begin bad++; $display("FAIL io_we got=%0h want=1", b0.io_we); end
    total++; if (b0.io_addr !== 8'h20) begin bad++; $display("FAIL io_wr_addr got=%0h want=20", b0.io_addr); end
    total++; if (b0.io_re !== 1'b0) begin bad++; $display("FAIL io_wr_re got=%0h want=0", b0.io_re); end
    @(negedge clock);
    total++; if (b0.io_we !== 1'b0) begin bad++; $display("FAIL io_we_pulse got=%0h want=0", b0.io_we); end
    total++; if (b0.io_wdata !== 8'hC3) begin bad++; $display("FAIL io_wdata_hold got=%0h want=c3", b0.io_wdata); end
    q0.push_back(8'h00);
    drive0(1'b0, 16'h0010, 8'h00);
    total++; if ({b0.io_re, b0.io_we, b0.dm_re, b0.dm_we, b0.ireg_we} !== 7'b0) begin
      bad++; $display("FAIL null_strobes got=%0b want=0", {b0.io_re, b0.io_we, b0.dm_re, b0.dm_we, b0.ireg_we}); end
    total++; if (b0.busy !== 1'b1) begin bad++; $display("FAIL null_busy got=%0h want=1", b0.busy); end
    wait_valid0(lat);
    total++; if (lat !== 2) begin bad++; $display("FAIL null_latency got=%0d want=2", lat); end
    total++;
    if (q0.size() == 0) begin bad++; $display("FAIL null_rd_data got=empty-queue want=00"); end
    else begin
      logic [7:0] e; e = q0.pop_front();
      if (b0.rd_data !== e) begin bad++; $display("FAIL null_rd_data got=%0h want=%0h", b0.rd_data, e); end
    end
  endtask

  task automatic test_decode_bounds;
    logic [15:0] addrs [6] = '{16'h001F, 16'h0020, 16'h005C, 16'h005D, 16'h00FF, 16'h0100};
    int          kinds [6] = '{0, 1, 1, 2, 1, 3};  // 0 null, 1 io, 2 ireg, 3 sram
    int lat;
    logic [7:0] ex;
    b0.ireg_rdata = 24'h80_22_11;
    b0.dm_ready   = 1'b1;
    for (int i = 0; i < 6; i++) begin
      b0.io_rdata = 8'h30 + 8'(i);
      b0.dm_rdata = 8'h60 + 8'(i);
      case (kinds[i])
        1:       ex = 8'h30 + 8'(i);
        2:       ex = 8'h11;
        3:       ex = 8'h60 + 8'(i);
        default: ex = 8'h00;
      endcase
      q0.push_back(ex);
      drive0(1'b0, addrs[i], 8'h00);
      total++; if (b0.io_re !== (kinds[i] == 1)) begin bad++; $display("FAIL dec_io_re[%0d] got=%0h want=%0h", i, b0.io_re, kinds[i] == 1); end
      total++; if (b0.dm_re !== (kinds[i] == 3)) begin bad++; $display("FAIL dec_dm_re[%0d] got=%0h want=%0h", i, b0.dm_re, kinds[i] == 3); end
      if (kinds[i] == 1) begin
        total++; if (b0.io_addr !== 8'(addrs[i] - 16'h0020)) begin bad++; $display("FAIL dec_io_addr[%0d] got=%0h want=%0h", i, b0.io_addr, 8'(addrs[i] - 16'h0020)); end
      end
      wait_valid0(lat);
      total++; if (lat !== 2) begin bad++; $display("FAIL dec_latency[%0d] got=%0d want=2", i, lat); end
      total++;
      if (q0.size() == 0) begin bad++; $display("FAIL dec_rd_data[%0d] got=empty-queue want=%0h", i, ex); end
      else begin
        logic [7:0] e; e = q0.pop_front();
        if (b0.rd_data !== e) begin bad++; $display("FAIL dec_rd_data[%0d] got=%0h want=%0h", i, b0.rd_data, e); end
      end
    end
    b0.dm_ready = 1'b0;
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 4; i++) begin
      b0.io_rdata = 8'hB0 + 8'(i);
      q0.push_back(8'hB0 + 8'(i));
      drive0(1'b0, 16'h0030 + 16'(i), 8'h00);
      total++; if (b0.io_addr !== 8'h10 + 8'(i)) begin bad++; $display("FAIL b2b_io_addr[%0d] got=%0h want=%0h", i, b0.io_addr, 8'h10 + 8'(i)); end
      @(negedge clock);
      total++; if (b0.rd_valid !== 1'b1 || b0.busy !== 1'b0) begin
        bad++; $display("FAIL b2b_valid[%0d] got=valid%0h/busy%0h want=valid1/busy0", i, b0.rd_valid, b0.busy); end
      total++;
      if (q0.size() == 0) begin bad++; $display("FAIL b2b_rd_data[%0d] got=empty-queue", i); end
      else begin
        logic [7:0] e; e = q0.pop_front();
        if (b0.rd_data !== e) begin bad++; $display("FAIL b2b_rd_data[%0d] got=%0h want=%0h", i, b0.rd_data, e); end
      end
    end
  endtask

  task automatic test_busy_ignore;
    b0.io_rdata = 8'h4E;
    q0.push_back(8'h4E);
    drive0(1'b0, 16'h0021, 8'h00);
    b0.req = 1'b1; b0.req_we = 1'b1; b0.req_addr = 16'h0300; b0.req_wdata = 8'hEE;
    @(negedge clock);
    b0.req = 1'b0; b0.req_we = 1'b0;
    total++;
    if (q0.size() == 0) begin bad++; $display("FAIL ign_rd_data got=empty-queue want=4e"); end
    else begin
      logic [7:0] e; e = q0.pop_front();
      if (b0.rd_data !== e || b0.rd_valid !== 1'b1) begin bad++; $display("FAIL ign_rd_data got=%0h/%0h want=%0h/1", b0.rd_data, b0.rd_valid, e); end
    end
    @(negedge clock);
    total++; if (b0.dm_we !== 1'b0 || b0.busy !== 1'b0) begin
      bad++; $display("FAIL ign_not_queued got=we%0h/busy%0h want=we0/busy0", b0.dm_we, b0.busy); end
  endtask

  task automatic test_timeout;
    int lat;
    b0.dm_ready = 1'b0;
    b0.dm_rdata = 8'h77;
    drive0(1'b0, 16'h0400, 8'h00);
`ifdef DM_TIMEOUT_EN
    q0.push_back(8'hFF);
    lat = 1;
    while (b0.err !== 1'b1 && lat < 40) begin @(negedge clock); lat++; end
    total++; if (lat !== 16) begin bad++; $display("FAIL to_err_latency got=%0d want=16", lat); end
    total++;
    if (q0.size() == 0) begin bad++; $display("FAIL to_rd_data got=empty-queue want=ff"); end
    else begin
      logic [7:0] e; e = q0.pop_front();
      if (b0.rd_data !== e || b0.rd_valid !== 1'b1) begin bad++; $display("FAIL to_rd_data got=%0h/%0h want=%0h/1", b0.rd_data, b0.rd_valid, e); end
    end
    @(negedge clock);
    total++; if (b0.err !== 1'b0 || b0.busy !== 1'b0) begin bad++; $display("FAIL to_err_pulse got=err%0h/busy%0h want=0/0", b0.err, b0.busy); end
`else
    begin
      int busy_n = 0, err_n = 0;
      for (int i = 0; i < 20; i++) begin
        if (b0.busy === 1'b1) busy_n++;
        if (b0.err !== 1'b0) err_n++;
        @(negedge clock);
      end
      total++; if (busy_n !== 20) begin bad++; $display("FAIL to_busy_hold got=%0d want=20", busy_n); end
      total++; if (err_n !== 0) begin bad++; $display("FAIL to_no_err got=%0d want=0", err_n); end
    end
    q0.push_back(8'h77);
    b0.dm_ready = 1'b1;
    wait_valid0(lat);
    total++; if (lat !== 2) begin bad++; $display("FAIL to_late_ready got=%0d want=2", lat); end
    total++;
    if (q0.size() == 0) begin bad++; $display("FAIL to_rd_data got=empty-queue want=77"); end
    else begin
      logic [7:0] e; e = q0.pop_front();
      if (b0.rd_data !== e) begin bad++; $display("FAIL to_rd_data got=%0h want=%0h", b0.rd_data, e); end
    end
`endif
    b0.dm_ready = 1'b0;
  endtask

  task automatic test_reset_mid;
    int lat;
    b2.dm_ready = 1'b0;
    drive2(1'b0, 16'h0200, 8'h00);
    total++; if (b2.dm_re !== 1'b1) begin bad++; $display("FAIL rm_dm_re got=%0h want=1", b2.dm_re); end
    @(negedge clock);
    reset = 1'b1;
    b2.req = 1'b1; b2.req_we = 1'b0; b2.req_addr = 16'h0020; b2.io_rdata = 8'h9C;
    @(negedge clock);
    total++; if (b2.dm_re !== 1'b0 || b2.busy !== 1'b0) begin
      bad++; $display("FAIL rm_abort got=re%0h/busy%0h want=0/0", b2.dm_re, b2.busy); end
    total++; if (b2.rd_valid !== 1'b0 || b2.err !== 1'b0) begin
      bad++; $display("FAIL rm_no_valid got=valid%0h/err%0h want=0/0", b2.rd_valid, b2.err); end
    reset = 1'b0;
    @(negedge clock);
    b2.req = 1'b0;
    total++; if (b2.io_re !== 1'b1 || b2.busy !== 1'b1) begin
      bad++; $display("FAIL rm_accept_after got=re%0h/busy%0h want=1/1", b2.io_re, b2.busy); end
    q2.push_back(8'h9C);
    lat = 1;
    while (b2.rd_valid !== 1'b1 && lat < 40) begin @(negedge clock); lat++; end
    total++; if (lat !== 2) begin bad++; $display("FAIL rm_latency got=%0d want=2", lat); end
    total++;
    if (q2.size() == 0) begin bad++; $display("FAIL rm_rd_data got=empty-queue want=9c"); end
    else begin
      logic [7:0] e; e = q2.pop_front();
      if (b2.rd_data !== e) begin bad++; $display("FAIL rm_rd_data got=%0h want=%0h", b2.rd_data, e); end
    end
  endtask

  initial begin
    test_reset();
    test_sram_read();
    test_sram_write_ws2();
    test_ireg();
    test_io_null();
    test_decode_bounds();
    test_back_to_back();
    test_busy_ignore();
    test_timeout();
    test_reset_mid();
    total++; if (q0.size() + q2.size() != 0) begin bad++; $display("FAIL scoreboard_drain got=%0d want=0", q0.size() + q2.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
